// File: rtl/hpdcache_mem_read_resp_router.sv
// Routes memory read responses back to the requester that issued the matching ID,
// and blocks new requests whose ID is still outstanding.
module hpdcache_mem_read_resp_router #(
    parameter int unsigned N                     = 1,
    parameter int unsigned ID_WIDTH              = 4,
    parameter type         hpdcache_mem_resp_r_t = logic,
    localparam type        gnt_index_t           = logic [(N > 1 ? $clog2(N) : 0):0]
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 mem_req_read_valid_i,
    output logic                 mem_req_read_ready_o,
    input  logic [ID_WIDTH-1:0]  mem_req_read_id_i,
    input  gnt_index_t           mem_req_read_index_i,
    output logic                 mem_req_read_valid_o,
    input  logic                 mem_req_read_ready_i,

    input  logic                 mem_resp_read_valid_i,
    output logic                 mem_resp_read_ready_o,
    input  logic [ID_WIDTH-1:0]  mem_resp_read_id_i,
    input  logic                 mem_resp_read_last_i,
    input  hpdcache_mem_resp_r_t mem_resp_read_i,
    output logic [N-1:0]         mem_resp_read_valid_o,
    input  logic [N-1:0]         mem_resp_read_ready_i,
    output hpdcache_mem_resp_r_t mem_resp_read_o,

    output logic [ID_WIDTH:0]    outstanding_o,
    output logic                 err_unknown_id_o
);

    localparam int unsigned DEPTH = 1 << ID_WIDTH;
    localparam int unsigned CNT_W = ID_WIDTH + 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    gnt_index_t       owner_q [DEPTH];
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             err_q, err_d;

    logic       id_free;
    logic       req_hs;
    logic       resp_hit;
    gnt_index_t resp_owner;
    logic       resp_ready_sel;
    logic       resp_hs;
    logic       resp_free;
    logic       resp_unknown;

    // Request path: an ID still in the table is held off so its response stays unambiguous.
    assign id_free              = ~busy_q[mem_req_read_id_i];
    assign mem_req_read_valid_o = mem_req_read_valid_i & id_free;
    assign mem_req_read_ready_o = mem_req_read_ready_i & id_free;
    assign req_hs               = mem_req_read_valid_i & mem_req_read_ready_i & id_free;

    // Response path looks up the registered table only.
    assign resp_hit   = busy_q[mem_resp_read_id_i];
    assign resp_owner = owner_q[mem_resp_read_id_i];

    always_comb begin
        resp_ready_sel = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            if (resp_owner == gnt_index_t'(k)) begin
                resp_ready_sel = mem_resp_read_ready_i[k];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < int'(N); gi++) begin : g_resp_valid
            assign mem_resp_read_valid_o[gi] = mem_resp_read_valid_i & resp_hit &
                                               (resp_owner == gnt_index_t'(gi));
        end
    endgenerate

    // Unknown IDs are accepted and dropped so memory never stalls on them.
    assign mem_resp_read_ready_o = resp_hit ? resp_ready_sel : 1'b1;
    assign mem_resp_read_o       = mem_resp_read_i;

    assign resp_hs      = mem_resp_read_valid_i & mem_resp_read_ready_o;
    assign resp_free    = resp_hs & resp_hit & mem_resp_read_last_i;
    assign resp_unknown = resp_hs & ~resp_hit;

    always_comb begin
        busy_d        = busy_q;
        outstanding_d = outstanding_q + CNT_W'(req_hs) - CNT_W'(resp_free);
        err_d         = err_q | resp_unknown;
        if (resp_free) begin
            busy_d[mem_resp_read_id_i] = 1'b0;
        end
        if (req_hs) begin
            busy_d[mem_req_read_id_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // Owner entries are only meaningful while their busy bit is set, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (req_hs) begin
            owner_q[mem_req_read_id_i] <= mem_req_read_index_i;
        end
    end

    assign outstanding_o    = outstanding_q;
    assign err_unknown_id_o = err_q;

endmodule
